ref_bank_loader: RTL and testbench

Write-side sequencer for the ME reference-pixel bank pair. Accepts a stream of 8-pixel reference words from the search-window fetch path via a valid/ready handshake. Drives the bank write port (`beg_en`, `ref_in`, `Bank_sel`) so that each bank is filled with DEPTH consecutive words, ping-ponging between bank 0 and bank 1. Per-bank full flags let the SAD/read side consume one bank while the other is filled.

---
 rtl/ref_bank_loader.sv | 90 +++++++++
 tb/tb_ref_bank_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ref_bank_loader.sv
// ref_bank_loader: ping-pong write sequencer filling two DEPTH-word reference banks.
// Optional REF_LOADER_STALL_CNT_EN adds a saturating stall_cnt output.
module ref_bank_loader #(
  parameter int PIXEL = 8,
  parameter int LANES = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int W = LANES * PIXEL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         src_ready,
  output logic         beg_en,
  output logic [W-1:0] ref_in,
  output logic         Bank_sel,
  output logic [AW-1:0] wr_addr,
  output logic [1:0]   bank_full,
  input  logic [1:0]   bank_release,
  output logic         busy
`ifdef REF_LOADER_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, wr_addr_q;
  logic sel_q, sel_d, beg_en_q, bank_sel_q, acc, last;
  logic [1:0] full_q, full_d;
  logic [W-1:0] ref_in_q;
  always_comb begin
    src_ready = state_q == FILL && !full_q[sel_q];
    acc = src_valid && src_ready && !flush;
    last = acc && cnt_q == AW'(DEPTH - 1);
    // set after release: a completing bank stays full even if released this cycle
    full_d = flush ? 2'b00 : (full_q & ~bank_release) | (last ? 2'b01 << sel_q : 2'b00);
    sel_d = flush ? 1'b0 : sel_q ^ last;
    cnt_d = flush ? '0 : cnt_q + AW'(acc);
    state_d = flush ? IDLE :
              state_q == IDLE ? (start ? FILL : IDLE) :
              state_q == FILL ? ((last && full_d[~sel_q]) ? WAIT : FILL) :
              (full_d[sel_q] ? WAIT : FILL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= 1'b0;
      full_q <= 2'b00;
      beg_en_q <= 1'b0;
      ref_in_q <= '0;
      bank_sel_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      full_q <= full_d;
      beg_en_q <= acc;
      if (acc) begin
        ref_in_q <= src_data;
        bank_sel_q <= sel_q;
        wr_addr_q <= cnt_q;
      end
    end
  end
  assign beg_en = beg_en_q;
  assign ref_in = ref_in_q;
  assign Bank_sel = bank_sel_q;
  assign wr_addr = wr_addr_q;
  assign bank_full = full_q;
  assign busy = state_q != IDLE;
`ifdef REF_LOADER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb begin
    stall_d = flush ? 16'h0 :
              (stall_q != 16'hFFFF && (state_q == WAIT || (state_q == FILL && src_valid && !src_ready))) ?
              stall_q + 16'h1 : stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'h0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_ref_bank_loader.sv
// tb_ref_bank_loader: randomized bench against a word-count model of the bank loader.
module tb_ref_bank_loader;
  localparam int DEPTH = 128;
  localparam int W = 64;
  logic clk = 0, rst_n = 0, start = 0, flush = 0, src_valid = 0;
  logic [W-1:0] src_data = '0;
  logic [1:0] bank_release = 2'b00;
  logic src_ready, beg_en, Bank_sel, busy;
  logic [W-1:0] ref_in;
  logic [6:0] wr_addr;
  logic [1:0] bank_full;
`ifdef REF_LOADER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, errors = 0;
  int n = 0, stall = 0;
  bit loading = 0;
  bit [1:0] mfull = 2'b00;
  logic [7:0] pat [4] = '{8'h0F, 8'h55, 8'hAA, 8'hF0};

  ref_bank_loader #(.PIXEL(8), .LANES(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .beg_en(beg_en), .ref_in(ref_in), .Bank_sel(Bank_sel), .wr_addr(wr_addr),
    .bank_full(bank_full), .bank_release(bank_release), .busy(busy)
`ifdef REF_LOADER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Words are numbered from start: word k lands in bank (k/DEPTH)%2 at address k%DEPTH.
  task automatic step(input logic v, input logic [W-1:0] d, input logic st, input logic fl,
                      input logic [1:0] rel);
    bit er, acc;
    int eb, ea;
    src_valid = v; src_data = d; start = st; flush = fl; bank_release = rel;
    eb = (n / DEPTH) % 2;
    ea = n % DEPTH;
    er = loading && !mfull[eb];
    #2 check("src_ready", src_ready, er);
    acc = v && er && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      loading = 0; n = 0; mfull = 2'b00; stall = 0;
    end else begin
      if (loading && !er && stall < 65535) stall++;
      mfull &= ~rel;
      if (acc) begin
        n++;
        if (n % DEPTH == 0) mfull[eb] = 1'b1;
      end
      if (st && !loading) loading = 1;
    end
    check("beg_en", beg_en, acc);
    if (acc) begin
      check("Bank_sel", Bank_sel, eb[0]);
      check("wr_addr", wr_addr, ea[6:0]);
      check("ref_in", ref_in, d);
    end
    check("bank_full", bank_full, mfull);
    check("busy", busy, loading);
`ifdef REF_LOADER_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall[15:0]);
`endif
    src_valid = 0; start = 0; flush = 0; bank_release = 2'b00;
  endtask

  task automatic check_reset_outputs();
    check("rst src_ready", src_ready, 0);
    check("rst beg_en", beg_en, 0);
    check("rst ref_in", ref_in, 0);
    check("rst Bank_sel", Bank_sel, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst bank_full", bank_full, 0);
    check("rst busy", busy, 0);
`ifdef REF_LOADER_STALL_CNT_EN
    check("rst stall_cnt", stall_cnt, 0);
`endif
  endtask

  initial begin
    logic [1:0] rel;
    int cur;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1;
    step(0, '0, 1, 0, 2'b00);
    for (int i = 0; i < 128; i++) step(1, {8{pat[i % 4]}}, 0, 0, 2'b00);
    for (int i = 0; i < 128; i++) step(1, rnd(), 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) step(1, rnd(), 0, 0, 2'b00);
    step(1, rnd(), 0, 0, 2'b01);
    for (int i = 0; i < 128; i++) step(i % 2 == 0, rnd(), 0, 0, 2'b00);
    step(0, '0, 0, 0, 2'b10);
    for (int i = 0; i < 600; i++) begin
      cur = (n / DEPTH) % 2;
      rel = 2'b00;
      for (int b = 0; b < 2; b++)
        if ((mfull[b] || b != cur) && $urandom_range(7) == 0) rel[b] = 1'b1;
      step($urandom_range(3) != 0, rnd(), $urandom_range(15) == 0, 0, rel);
    end
    step(0, '0, 0, 1, 2'b00);
    step(0, '0, 1, 0, 2'b00);
    for (int i = 0; i < 228; i++) step(1, rnd(), 0, 0, 2'b00);
    step(1, rnd(), 1, 1, 2'b00);
    step(0, '0, 0, 0, 2'b00);
    step(0, '0, 1, 0, 2'b00);
    for (int i = 0; i < 37; i++) step(1, rnd(), 0, 0, 2'b00);
    src_valid = 1;
    #2 rst_n = 0;
    #1 check_reset_outputs();
    loading = 0; n = 0; mfull = 2'b00; stall = 0;
    src_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    step(0, '0, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
